system_sw_ctrl: RTL

//   Debounce, edge-capture and interrupt controller for the slide-switch input

---
 rtl/system_sw_pkg.sv | 16 +
 rtl/system_sw_ctrl_debounce.sv | 52 +++++
 rtl/system_sw_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/system_sw_pkg.sv
// Shared constants for the slide-switch controller: Avalon register offsets
// and the edge-capture selections.
package system_sw_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MASK = 2'd1,
    REG_RAW  = 2'd2,
    REG_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/system_sw_ctrl_debounce.sv
// One switch bit: 2-FF synchroniser, hold counter and debounced stable flop.
module sw_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic stable
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_meta_reg;
  logic          sync_reg;
  logic          stable_reg;
  logic          stable_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      stable_reg    <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      sync_meta_reg <= pin;
      sync_reg      <= sync_meta_reg;
      stable_reg    <= stable_next;
      cnt_reg       <= cnt_next;
    end
  end

  // The counter restarts on the accepting cycle, so it tops out at CNT_LAST.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (sync_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = sync_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign sync   = sync_reg;
  assign stable = stable_reg;

endmodule

// File: rtl/system_sw_ctrl.sv
// Slide-switch controller: per-bit debounce, sticky edge capture, interrupt
// mask and an Avalon-MM slave with registered zero-wait-state reads.
module system_sw_ctrl
  import system_sw_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int DB_CYCLES = 50000,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] stable_d_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] new_edge;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             wr_en;
  logic             unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_db
      sw_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk    (clk),
        .reset  (reset),
        .pin    (in_port[gi]),
        .sync   (sync_w[gi]),
        .stable (stable_w[gi])
      );
    end

    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign new_edge = stable_w & ~stable_d_reg;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign new_edge = ~stable_w & stable_d_reg;
    end else begin : g_any
      assign new_edge = stable_w ^ stable_d_reg;
    end
  endgenerate

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // A fresh edge overrides a same-cycle clear so no event is ever lost.
  always_comb begin
    edge_clr  = '0;
    mask_next = mask_reg;
    if (wr_en && (address == REG_EDGE)) edge_clr  = writedata[WIDTH-1:0];
    if (wr_en && (address == REG_MASK)) mask_next = writedata[WIDTH-1:0];
    edge_next = (edge_reg & ~edge_clr) | new_edge;
  end

  always_comb begin
    readdata_next = '0;
    case (reg_addr_e'(address))
      REG_DATA: readdata_next[WIDTH-1:0] = stable_w;
      REG_MASK: readdata_next[WIDTH-1:0] = mask_reg;
      REG_RAW:  readdata_next[WIDTH-1:0] = sync_w;
      REG_EDGE: readdata_next[WIDTH-1:0] = edge_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d_reg <= '0;
      mask_reg     <= '0;
      edge_reg     <= '0;
      readdata_reg <= '0;
    end else begin
      stable_d_reg <= stable_w;
      mask_reg     <= mask_next;
      edge_reg     <= edge_next;
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edge_reg & mask_reg);

endmodule
